// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
package muldiv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    WRITE,
    DONE,
    EXC
  } state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int DEF_MULT_CYCLES = 32;
  localparam int DEF_DIV_CYCLES  = 32;
  localparam int DEF_CNT_W       = 6;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Handshake between the main control unit (master) and the muldiv sequencer (slave).
interface muldiv_sequencer_if;
  logic        start;
  logic        op;
  logic [31:0] divisor;
  logic        kill;
  logic        unit_start;
  logic        div_or_mult;
  logic        hilo_w;
  logic        busy;
  logic        done;
  logic        div0;

  modport master (
    output start, op, divisor, kill,
    input  unit_start, div_or_mult, hilo_w, busy, done, div0
  );

  modport slave (
    input  start, op, divisor, kill,
    output unit_start, div_or_mult, hilo_w, busy, done, div0
  );
endinterface

// File: rtl/muldiv_cycle_counter.sv
// Iteration down-counter: loaded with N-1, decrements while enabled, saturates at zero.
module muldiv_cycle_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= load_value;
    else if (dec && count != '0)
      count <= count - CNT_W'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequencer for the shared multiplier/divider and HI/LO write-back.
// Define MULDIV_DIV0_TRAP_EN to compile in the divide-by-zero trap (EXC path, div0 pulse).
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input logic              clk,
  input logic              reset,
  muldiv_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  state_t state, next_state;
  logic   op_q;
  logic   trap;
  logic   cnt_zero;
  logic   unit_start, hilo_w_raw, busy, done_raw;

`ifdef MULDIV_DIV0_TRAP_EN
  assign trap     = (bus.op == OP_DIV) && (bus.divisor == 32'd0);
  assign bus.div0 = (state == EXC) && !bus.kill;
`else
  logic unused_divisor;
  assign unused_divisor = ^bus.divisor;
  assign trap     = 1'b0;
  assign bus.div0 = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      op_q  <= OP_MULT;
    end else begin
      state <= next_state;
      if (state == IDLE && bus.start && !bus.kill)
        op_q <= bus.op;
    end
  end

  // kill aborts from any state; in IDLE it also blocks a same-cycle start.
  always_comb begin
    next_state = state;
    unit_start = 1'b0;
    hilo_w_raw = 1'b0;
    done_raw   = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (bus.start)
          next_state = trap ? EXC : LOAD;
      end
      LOAD: begin
        unit_start = 1'b1;
        next_state = RUN;
      end
      RUN: begin
        if (cnt_zero)
          next_state = WRITE;
      end
      WRITE: begin
        hilo_w_raw = 1'b1;
        next_state = DONE;
      end
      DONE: begin
        done_raw   = 1'b1;
        next_state = IDLE;
      end
      EXC: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
    if (bus.kill)
      next_state = IDLE;
  end

  muldiv_cycle_counter #(
    .CNT_W(CNT_W)
  ) u_counter (
    .clk       (clk),
    .reset     (reset),
    .load      (state == LOAD),
    .load_value((op_q == OP_DIV) ? DIV_LOAD : MULT_LOAD),
    .dec       (state == RUN),
    .zero      (cnt_zero)
  );

  assign bus.unit_start  = unit_start;
  assign bus.busy        = busy;
  assign bus.hilo_w      = hilo_w_raw && !bus.kill;
  assign bus.done        = done_raw && !bus.kill;
  assign bus.div_or_mult = ~op_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench: directed scenarios plus random traffic against a
// cycle-timeline reference model of the sequencer handshake.
module tb_muldiv_sequencer;

  localparam int TB_MULT_CYCLES = 32;
  localparam int TB_DIV_CYCLES  = 32;
`ifdef MULDIV_DIV0_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   cycle;
  logic last_done;

  // Reference model: cycles elapsed since the accepted start, plus latched op.
  bit m_active;
  int m_t;
  bit m_op;
  bit m_trap;
  int m_n;

  muldiv_sequencer_if bus();

  muldiv_sequencer #(
    .MULT_CYCLES(TB_MULT_CYCLES),
    .DIV_CYCLES (TB_DIV_CYCLES),
    .CNT_W      (6)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d got=%0h expected=%0h", tag, cycle, obs, exp);
    end
  endtask

  task automatic checkCycle(input logic k);
    logic e_busy, e_us, e_hw, e_done, e_div0, e_dom;
    e_busy = m_active;
    e_us   = m_active && !m_trap && (m_t == 1);
    e_hw   = m_active && !m_trap && (m_t == m_n + 2) && !k;
    e_done = m_active && !m_trap && (m_t == m_n + 3) && !k;
    e_div0 = m_active && m_trap && !k;
    e_dom  = ~m_op;
    checkOutput("busy",        {31'b0, bus.busy},        {31'b0, e_busy});
    checkOutput("unit_start",  {31'b0, bus.unit_start},  {31'b0, e_us});
    checkOutput("hilo_w",      {31'b0, bus.hilo_w},      {31'b0, e_hw});
    checkOutput("done",        {31'b0, bus.done},        {31'b0, e_done});
    checkOutput("div0",        {31'b0, bus.div0},        {31'b0, e_div0});
    checkOutput("div_or_mult", {31'b0, bus.div_or_mult}, {31'b0, e_dom});
  endtask

  task automatic advanceModel(input logic s, input logic o, input logic [31:0] d,
                              input logic k, input logic r);
    if (r) begin
      m_active = 1'b0;
      m_op     = 1'b0;
      m_t      = 0;
    end else if (m_active) begin
      if (k || m_trap || m_t == m_n + 3)
        m_active = 1'b0;
      else
        m_t++;
    end else if (s && !k) begin
      m_active = 1'b1;
      m_t      = 1;
      m_op     = o;
      m_trap   = TRAP_EN && o && (d == 32'd0);
      m_n      = o ? TB_DIV_CYCLES : TB_MULT_CYCLES;
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance the model at the edge.
  task automatic applyStimulus(input logic s, input logic o, input logic [31:0] d,
                               input logic k, input logic r);
    bus.start   = s;
    bus.op      = o;
    bus.divisor = d;
    bus.kill    = k;
    reset       = r;
    @(negedge clk);
    checkCycle(k);
    last_done = bus.done;
    @(posedge clk);
    advanceModel(s, o, d, k, r);
    cycle++;
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  initial begin
    int latency;
    checks      = 0;
    failures    = 0;
    cycle       = 0;
    last_done   = 1'b0;
    m_active    = 1'b0;
    m_t         = 0;
    m_op        = 1'b0;
    m_trap      = 1'b0;
    m_n         = TB_MULT_CYCLES;
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.op      = 1'b0;
    bus.divisor = 32'd0;
    bus.kill    = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    $display("[TB] reset checked");

    // MULT, DIV by 7, DIV by 0
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    idleCycles(40);
    applyStimulus(1'b1, 1'b1, 32'd7, 1'b0, 1'b0);
    idleCycles(40);
    applyStimulus(1'b1, 1'b1, 32'd0, 1'b0, 1'b0);
    idleCycles(40);

    // kill at cycle 10 of a MULT, restart in cycle 11
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    idleCycles(9);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    idleCycles(40);

    // start during RUN is ignored
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    idleCycles(5);
    applyStimulus(1'b1, 1'b1, 32'd3, 1'b0, 1'b0);
    idleCycles(40);

    // start and kill together in IDLE
    applyStimulus(1'b1, 1'b1, 32'd9, 1'b1, 1'b0);
    idleCycles(3);

    // reset at cycle 5 of a DIV
    applyStimulus(1'b1, 1'b1, 32'd5, 1'b0, 1'b0);
    idleCycles(4);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    idleCycles(3);

    // back-to-back MULT then DIV with measured completion latency
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    idleCycles(35);
    applyStimulus(1'b1, 1'b1, 32'd11, 1'b0, 1'b0);
    latency = 0;
    for (int i = 1; i <= 60; i++) begin
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
      if (last_done) begin
        latency = i;
        break;
      end
    end
    checkOutput("b2b_latency", latency, TB_DIV_CYCLES + 3);
    idleCycles(2);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic        s, o, k, r;
      logic [31:0] d;
      s = ($urandom_range(3) == 0);
      o = 1'($urandom_range(1));
      d = ($urandom_range(2) == 0) ? 32'd0 : $urandom;
      k = ($urandom_range(24) == 0);
      r = ($urandom_range(149) == 0);
      applyStimulus(s, o, d, k, r);
    end
    idleCycles(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Sequencer for the shared iterative multiplier/divider and the HI/LO register pair in the multicycle CPU. The main control unit issues a one-cycle start with the operation type. The block then does the following:
- pulses the arithmetic units;
- counts their iteration cycles;
- drives the HI/LO source-select and write-enable;
- reports busy and done back to the control unit, plus divide-by-zero when that check is compiled in.

It replaces fixed wait states in the control unit with an explicit handshake.

## Interface
- MULT_CYCLES, 32: iteration cycles the multiplier needs after its start pulse (≥1)
- DIV_CYCLES, 32: iteration cycles the divider needs after its start pulse (≥1)
- CNT_W, 6: counter width; must hold max(MULT_CYCLES, DIV_CYCLES)-1
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request from the control unit; sampled only in IDLE
- op  in  1  0 = MULT, 1 = DIV; sampled with start
- divisor  in  32  Reg_B value, sampled with start
- kill  in  1  abort the current operation (exception or flush)
- unit_start  out  1  one-cycle start pulse to the selected unit
- div_or_mult  out  1  HI/LO source select: 0 = divider outputs, 1 = multiplier outputs
- hilo_w  out  1  HI/LO write-enable
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- div0  out  1  one-cycle divide-by-zero indication

## Operation
States:
- IDLE
  - start=1 and kill=0: latch op and select the count.
  - DIV with divisor==0, when trapping is enabled: go to EXC.
  - Otherwise: go to LOAD.
- LOAD
  - unit_start=1.
  - Counter is loaded with N-1, where N is MULT_CYCLES or DIV_CYCLES according to the latched op.
  - Next state: RUN.
- RUN
  - Counter decrements once per cycle.
  - Counter==0: go to WRITE.
- WRITE
  - hilo_w=1.
  - Next state: DONE.
- DONE
  - done=1.
  - Next state: IDLE.
- EXC
  - div0=1.
  - Next state: IDLE.
  - No unit_start and no hilo_w.

General rules:
- div_or_mult = ~latched_op in every state and holds its last value in IDLE. It is therefore stable before and during hilo_w.
- kill=1 in any non-IDLE state forces IDLE on the next edge. While kill is high, hilo_w, done and div0 are forced 0 combinationally.
- start while busy is ignored; there is no queueing.
- In IDLE, start and kill in the same cycle: kill wins and nothing starts.
- The counter never wraps; it is loaded only in LOAD.

## Timing
- Reset values:
  - state IDLE, counter 0, latched op 0;
  - unit_start, hilo_w, busy, done and div0 are all 0;
  - div_or_mult is 1.
- Reset mid-operation behaves like kill, but also clears the latched op.
- Normal operation, with start at cycle 0:
  - LOAD at cycle 1;
  - RUN at cycles 2 .. N+1;
  - WRITE at cycle N+2;
  - DONE at cycle N+3.
  - Total: done asserts N+3 cycles after start.
- busy rises at cycle 1 and falls one cycle after done.
- Back-to-back: a new start is accepted in the cycle immediately after DONE.
- Divide-by-zero: start at cycle 0 → div0 at cycle 1 → IDLE at cycle 2, with busy high only in cycle 1.
- All outputs are Moore-style (decoded from state), except the kill gating described under Operation.

## Configuration
- MULDIV_DIV0_TRAP_EN defined:
  - DIV with divisor==0 takes the EXC path;
  - HI/LO are untouched;
  - div0 is pulsed.
- MULDIV_DIV0_TRAP_EN undefined:
  - the zero check is not compiled;
  - DIV by zero runs the full LOAD/RUN/WRITE/DONE sequence and HI/LO take whatever the divider produces;
  - div0 is tied to 0 and state EXC is unreachable.

## Structure
- Shared package muldiv_pkg holds:
  - the state enum (IDLE, LOAD, RUN, WRITE, DONE, EXC);
  - the op encodings OP_MULT=0 and OP_DIV=1;
  - the default cycle constants.
- One sub-module, muldiv_cycle_counter:
  - inputs: load, load value, decrement enable;
  - output: zero flag;
  - it is the only place that holds the iteration count.

## Test plan
- MULT, start with op=0, MULT_CYCLES=32:
  - unit_start at cycle 1;
  - hilo_w at cycle 34 with div_or_mult=1;
  - done at cycle 35;
  - busy at cycles 1–35.
- DIV with divisor=7, DIV_CYCLES=32:
  - hilo_w at cycle 34 with div_or_mult=0;
  - done at cycle 35;
  - div0 stays 0.
- DIV with divisor=0:
  - with MULDIV_DIV0_TRAP_EN: div0 at cycle 1, no unit_start, no hilo_w, busy only in cycle 1;
  - without it: same timing as the DIV scenario above, with div0 never asserted.
- kill at cycle 10 of a MULT:
  - IDLE at cycle 11;
  - no hilo_w and no done;
  - a new start at cycle 11 is accepted.
- Simultaneous events:
  - start during RUN: ignored, sequence unchanged.
  - start and kill together in IDLE: nothing starts.
  - reset asserted at cycle 5: all outputs return to their reset values at the next edge.
- Back-to-back MULT then DIV:
  - second start in the cycle after the first done;
  - second done exactly 35 cycles after the second start.
